alu_seq4: RTL and testbench
===========================

ALU_SEQ4 -- requirements
Module: alu_seq4

Interface
REQ-001 SHALL have parameter: READ_WAIT, 0, extra cycles read enables held before operand capture (0..3).
REQ-002 SHALL have port: clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: cmd_valid in 1 / cmd_ready out 1  command handshake.
REQ-005 SHALL have ports: cmd_op in 3, cmd_rd in 4, cmd_rs1 in 4, cmd_rs2 in 4  opcode, destination, sources.
REQ-006 SHALL have ports: rd_addr1 out 4, rd_en1 out 1, rd_addr2 out 4, rd_en2 out 1  dual-port register-file read controls.
REQ-007 SHALL have ports: rd_data1 in 4, rd_data2 in 4  register-file read data (tristate bus, Z when enable low).
REQ-008 SHALL have ports: wr_addr out 4, wr_en out 1, wr_data out 4  register-file write controls.
REQ-009 SHALL have ports: carry out 1, zero out 1  flags; done out 1  one-cycle completion pulse.

Function
REQ-010 SHALL implement FSM states IDLE, READ, WAIT, EXEC, WRITE.
REQ-011 IDLE: cmd_ready=1; cmd_valid&cmd_ready at an edge latches op/rd/rs1/rs2 -> READ; else stay.
REQ-012 cmd_ready SHALL be 0 in every state except IDLE; commands offered outside IDLE are ignored, not queued.
REQ-013 READ and WAIT: rd_en1=rd_en2=1, rd_addr1=latched rs1, rd_addr2=latched rs2; otherwise enables 0, addresses 0.
REQ-014 READ -> EXEC when READ_WAIT=0, else READ -> WAIT; WAIT holds READ_WAIT cycles (counter) then -> EXEC.
REQ-015 rd_data1/rd_data2 SHALL be sampled only at the last edge with enables high; never sampled while enables low.
REQ-016 EXEC: registers 4-bit result and carry-out from captured operands, one cycle, -> WRITE.
REQ-017 Ops: 000 ADD a+b; 001 ADC a+b+carry; 010 SUB a-b, carry=1 means no borrow; 011 AND; 100 OR; 101 XOR; 110 MOV a; 111 NOT a.
REQ-018 Arithmetic SHALL use 5-bit sum, result=bits[3:0], carry=bit4; wrap-around modulo 16.
REQ-019 Logic/MOV/NOT ops SHALL leave carry unchanged.
REQ-020 WRITE: wr_en=1, wr_addr=latched rd, wr_data=result for exactly one cycle; -> IDLE.
REQ-021 carry and zero (result==0) SHALL update at the edge ending WRITE; done=1 in the following IDLE cycle only.
REQ-022 Latency (READ_WAIT=0): handshake edge T; READ cycle T+1; EXEC T+2; WRITE T+3; done and cmd_ready high cycle T+4.
REQ-023 rd equal to rs1/rs2 SHALL be legal; sources read before write.
REQ-024 Back-to-back commands: next command read SHALL observe previous write (write completes before next READ).
REQ-025 wr_en SHALL never be asserted in any state except WRITE.

Reset
REQ-026 reset asserted SHALL immediately force IDLE, cmd_ready=1, all enables 0, addresses/wr_data 0, carry=0, zero=0, done=0, wait counter 0.
REQ-027 reset mid-operation SHALL abort the command with no write; no done pulse for it.
REQ-028 reset deassertion SHALL take effect at next clk edge; no command accepted while reset high.

Structure
REQ-029 Opcode encodings and FSM state encoding SHALL live in shared package alu4_pkg.
REQ-030 Datapath SHALL be a sub-module alu4 (combinational: op, a, b, cin -> result, cout); FSM and registers in alu_seq4.

Verification (bench uses behavioural 16x4 dual-read register file)
REQ-031 Preload r1=9, r2=8; ADD rd=3,rs1=1,rs2=2 -> wr_addr=3, wr_data=1, carry=1, zero=0, done at T+4.
REQ-032 Then ADC rd=4,r1,r2 (carry=1) -> wr_data=2, carry=1; SUB rd=5,r2,r1 -> wr_data=F, carry=0.
REQ-033 r6=A, r7=A; XOR rd=6,r6,r7 -> r6=0, zero=1, carry unchanged; following MOV rd=8,rs1=6 reads 0.
REQ-034 READ_WAIT=2: rd_en high 3 cycles, bus Z outside enables, result correct, done at T+6.
REQ-035 reset asserted during EXEC -> no wr_en pulse, no done, cmd_ready=1 immediately, flags 0.
REQ-036 cmd_valid held high continuously for 3 commands -> each accepted only in IDLE, exactly 3 writes, 3 done pulses.

Source files
------------

// File: rtl/alu4_pkg.sv
// Shared opcode and FSM state encodings for the sequenced 4-bit ALU.
package alu4_pkg;

  localparam int unsigned DataW = 4;
  localparam int unsigned AddrW = 4;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpAdc = 3'b001,
    OpSub = 3'b010,
    OpAnd = 3'b011,
    OpOr  = 3'b100,
    OpXor = 3'b101,
    OpMov = 3'b110,
    OpNot = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StExec,
    StWrite
  } alu_state_e;

endpackage

// File: rtl/alu4.sv
// Combinational 4-bit ALU datapath; logic ops pass the incoming carry through.
module alu4
  import alu4_pkg::*;
(
  input  alu_op_e          op,
  input  logic [DataW-1:0] a,
  input  logic [DataW-1:0] b,
  input  logic             cin,
  output logic [DataW-1:0] result,
  output logic             cout
);

  logic [DataW:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    cout   = cin;
    unique case (op)
      OpAdd: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DataW-1:0];
        cout   = sum[DataW];
      end
      OpAdc: begin
        sum    = {1'b0, a} + {1'b0, b} + {{DataW{1'b0}}, cin};
        result = sum[DataW-1:0];
        cout   = sum[DataW];
      end
      OpSub: begin
        // Two's-complement subtract: carry set means no borrow.
        sum    = {1'b0, a} + {1'b0, ~b} + {{DataW{1'b0}}, 1'b1};
        result = sum[DataW-1:0];
        cout   = sum[DataW];
      end
      OpAnd: result = a & b;
      OpOr:  result = a | b;
      OpXor: result = a ^ b;
      OpMov: result = a;
      OpNot: result = ~a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq4.sv
// Sequenced ALU: read two registers, execute, write back, then update flags.
module alu_seq4
  import alu4_pkg::*;
#(
  parameter int unsigned READ_WAIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AddrW-1:0] cmd_rd,
  input  logic [AddrW-1:0] cmd_rs1,
  input  logic [AddrW-1:0] cmd_rs2,
  output logic [AddrW-1:0] rd_addr1,
  output logic             rd_en1,
  output logic [AddrW-1:0] rd_addr2,
  output logic             rd_en2,
  input  logic [DataW-1:0] rd_data1,
  input  logic [DataW-1:0] rd_data2,
  output logic [AddrW-1:0] wr_addr,
  output logic             wr_en,
  output logic [DataW-1:0] wr_data,
  output logic             carry,
  output logic             zero,
  output logic             done
);

  localparam logic [1:0] WaitLast = (READ_WAIT > 0) ? 2'(READ_WAIT - 1) : 2'd0;

  alu_state_e       state;
  alu_op_e          op_q;
  logic [AddrW-1:0] rd_q;
  logic [DataW-1:0] a_q;
  logic [DataW-1:0] b_q;
  logic             res_carry_q;
  logic [1:0]       wait_cnt;

  logic [DataW-1:0] alu_result;
  logic             alu_cout;

  alu4 u_alu4 (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .cin    (carry),
    .result (alu_result),
    .cout   (alu_cout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      op_q        <= OpAdd;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_carry_q <= 1'b0;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b1;
      rd_addr1    <= '0;
      rd_addr2    <= '0;
      rd_en1      <= 1'b0;
      rd_en2      <= 1'b0;
      wr_addr     <= '0;
      wr_en       <= 1'b0;
      wr_data     <= '0;
      carry       <= 1'b0;
      zero        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (cmd_valid) begin
            op_q      <= alu_op_e'(cmd_op);
            rd_q      <= cmd_rd;
            rd_addr1  <= cmd_rs1;
            rd_addr2  <= cmd_rs2;
            rd_en1    <= 1'b1;
            rd_en2    <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= StRead;
          end
        end
        StRead: begin
          if (READ_WAIT == 0) begin
            a_q      <= rd_data1;
            b_q      <= rd_data2;
            rd_en1   <= 1'b0;
            rd_en2   <= 1'b0;
            rd_addr1 <= '0;
            rd_addr2 <= '0;
            state    <= StExec;
          end else begin
            wait_cnt <= '0;
            state    <= StWait;
          end
        end
        StWait: begin
          // Operands are captured only on the final edge with enables high.
          if (wait_cnt == WaitLast) begin
            a_q      <= rd_data1;
            b_q      <= rd_data2;
            rd_en1   <= 1'b0;
            rd_en2   <= 1'b0;
            rd_addr1 <= '0;
            rd_addr2 <= '0;
            wait_cnt <= '0;
            state    <= StExec;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        StExec: begin
          wr_data     <= alu_result;
          res_carry_q <= alu_cout;
          wr_addr     <= rd_q;
          wr_en       <= 1'b1;
          state       <= StWrite;
        end
        StWrite: begin
          carry     <= res_carry_q;
          zero      <= (wr_data == '0);
          done      <= 1'b1;
          wr_en     <= 1'b0;
          wr_addr   <= '0;
          wr_data   <= '0;
          cmd_ready <= 1'b1;
          state     <= StIdle;
        end
        default: begin
          state     <= StIdle;
          cmd_ready <= 1'b1;
          rd_en1    <= 1'b0;
          rd_en2    <= 1'b0;
          wr_en     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq4.sv
// Bench for alu_seq4: two instances (READ_WAIT 0 and 2) each with a 16x4 register file.
module tb_alu_seq4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [2:0] cmd_op    [2];
  logic [3:0] cmd_rd    [2];
  logic [3:0] cmd_rs1   [2];
  logic [3:0] cmd_rs2   [2];
  logic [3:0] rd_addr1  [2];
  logic [3:0] rd_addr2  [2];
  logic       rd_en1    [2];
  logic       rd_en2    [2];
  logic [3:0] wr_addr   [2];
  logic [3:0] wr_data   [2];
  logic       wr_en     [2];
  logic       carry     [2];
  logic       zero      [2];
  logic       done      [2];
  logic       pre_en    [2];
  logic [3:0] pre_addr  [2];
  logic [3:0] pre_data  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [3:0] mem [16];
    wire  [3:0] bus1;
    wire  [3:0] bus2;

    assign bus1 = rd_en1[g] ? mem[rd_addr1[g]] : 4'bz;
    assign bus2 = rd_en2[g] ? mem[rd_addr2[g]] : 4'bz;

    always @(posedge clk) begin
      if (wr_en[g]) mem[wr_addr[g]] <= wr_data[g];
      else if (pre_en[g]) mem[pre_addr[g]] <= pre_data[g];
    end

    alu_seq4 #(
      .READ_WAIT(g == 0 ? 0 : 2)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid[g]),
      .cmd_ready (cmd_ready[g]),
      .cmd_op    (cmd_op[g]),
      .cmd_rd    (cmd_rd[g]),
      .cmd_rs1   (cmd_rs1[g]),
      .cmd_rs2   (cmd_rs2[g]),
      .rd_addr1  (rd_addr1[g]),
      .rd_en1    (rd_en1[g]),
      .rd_addr2  (rd_addr2[g]),
      .rd_en2    (rd_en2[g]),
      .rd_data1  (bus1),
      .rd_data2  (bus2),
      .wr_addr   (wr_addr[g]),
      .wr_en     (wr_en[g]),
      .wr_data   (wr_data[g]),
      .carry     (carry[g]),
      .zero      (zero[g]),
      .done      (done[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;
  int exp_rf [2][16];
  int exp_c  [2];
  int exp_z  [2];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference behaviour from the opcode table, in plain integer arithmetic.
  task automatic model(input int op, input int a, input int b, input int cin,
                       output int r, output int c);
    c = cin;
    case (op)
      0: begin r = (a + b) % 16; c = (a + b) / 16; end
      1: begin r = (a + b + cin) % 16; c = (a + b + cin) / 16; end
      2: begin r = (a - b + 16) % 16; c = (a >= b) ? 1 : 0; end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = a;
      default: r = 15 - a;
    endcase
  endtask

  task automatic wait_ready(input int k, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (cmd_ready[k]) begin
        ok = 1'b1;
        break;
      end
    end
    check("ready_wait", int'(ok), 1);
  endtask

  task automatic do_cmd(input int k, input int op, input int rd, input int rs1, input int rs2);
    int rw, r, c, wr_cnt, wr_cyc, wr_a, wr_d, done_cyc, en1_cnt, en2_cnt, busy_ready, rdy_done;
    bit ok;
    rw = (k == 0) ? 0 : 2;
    wait_ready(k, ok);
    if (!ok) return;
    model(op, exp_rf[k][rs1], exp_rf[k][rs2], exp_c[k], r, c);
    cmd_valid[k] = 1'b1;
    cmd_op[k]    = 3'(op);
    cmd_rd[k]    = 4'(rd);
    cmd_rs1[k]   = 4'(rs1);
    cmd_rs2[k]   = 4'(rs2);
    @(posedge clk);
    #1 cmd_valid[k] = 1'b0;
    wr_cnt = 0; wr_cyc = -1; wr_a = -1; wr_d = -1; done_cyc = -1;
    en1_cnt = 0; en2_cnt = 0; busy_ready = 0; rdy_done = 0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (t == 1) begin
        check("rd_addr1", int'(rd_addr1[k]), rs1);
        check("rd_addr2", int'(rd_addr2[k]), rs2);
      end
      if (rd_en1[k]) en1_cnt++;
      if (rd_en2[k]) en2_cnt++;
      if (wr_en[k]) begin
        wr_cnt++; wr_cyc = t; wr_a = int'(wr_addr[k]); wr_d = int'(wr_data[k]);
      end
      if (done[k]) begin
        done_cyc = t; rdy_done = int'(cmd_ready[k]);
        break;
      end
      if (cmd_ready[k]) busy_ready++;
    end
    check("rd_en1_cycles", en1_cnt, 1 + rw);
    check("rd_en2_cycles", en2_cnt, 1 + rw);
    check("wr_count", wr_cnt, 1);
    check("wr_cycle", wr_cyc, 3 + rw);
    check("wr_addr", wr_a, rd);
    check("wr_data", wr_d, r);
    check("done_cycle", done_cyc, 4 + rw);
    check("ready_busy", busy_ready, 0);
    check("ready_done", rdy_done, 1);
    check("carry", int'(carry[k]), c);
    check("zero", int'(zero[k]), (r == 0) ? 1 : 0);
    exp_rf[k][rd] = r;
    exp_c[k] = c;
    exp_z[k] = (r == 0) ? 1 : 0;
  endtask

  task automatic reset_in_exec();
    bit ok, seen;
    wait_ready(0, ok);
    if (!ok) return;
    cmd_valid[0] = 1'b1; cmd_op[0] = 3'd0; cmd_rd[0] = 4'd3; cmd_rs1[0] = 4'd1; cmd_rs2[0] = 4'd2;
    @(posedge clk);
    #1 cmd_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_ready", int'(cmd_ready[0]), 1);
    check("rst_wr_en", int'(wr_en[0]), 0);
    check("rst_rd_en", int'(rd_en1[0] | rd_en2[0]), 0);
    check("rst_carry", int'(carry[0]), 0);
    check("rst_zero", int'(zero[0]), 0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (wr_en[0] || done[0]) seen = 1'b1;
    end
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (wr_en[0] || done[0]) seen = 1'b1;
    end
    check("rst_no_write_done", int'(seen), 0);
    for (int k = 0; k < 2; k++) begin
      exp_c[k] = 0;
      exp_z[k] = 0;
    end
  endtask

  task automatic back_to_back();
    int hs, writes, dones, r, c;
    bit ok;
    wait_ready(0, ok);
    if (!ok) return;
    hs = 0; writes = 0; dones = 0;
    cmd_valid[0] = 1'b1; cmd_op[0] = 3'd0; cmd_rd[0] = 4'd9; cmd_rs1[0] = 4'd9; cmd_rs2[0] = 4'd1;
    for (int t = 0; t <= 16; t++) begin
      if (t > 0) @(negedge clk);
      if (wr_en[0]) begin
        writes++;
        model(0, exp_rf[0][9], exp_rf[0][1], exp_c[0], r, c);
        check("b2b_wdata", int'(wr_data[0]), r);
        exp_rf[0][9] = r;
        exp_c[0] = c;
        exp_z[0] = (r == 0) ? 1 : 0;
      end
      if (done[0]) dones++;
      if (cmd_ready[0] && cmd_valid[0]) begin
        hs++;
        check("b2b_accept_cycle", t, (hs - 1) * 4);
        if (hs == 3) begin
          @(posedge clk);
          #1 cmd_valid[0] = 1'b0;
        end
      end
    end
    check("b2b_writes", writes, 3);
    check("b2b_dones", dones, 3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 1'b0; cmd_op[k] = '0; cmd_rd[k] = '0; cmd_rs1[k] = '0; cmd_rs2[k] = '0;
      pre_en[k] = 1'b0; pre_addr[k] = '0; pre_data[k] = '0;
      exp_c[k] = 0; exp_z[k] = 0;
      for (int a = 0; a < 16; a++) exp_rf[k][a] = int'($urandom_range(0, 15));
    end
    exp_rf[0][1] = 9; exp_rf[0][2] = 8; exp_rf[0][6] = 10; exp_rf[0][7] = 10;

    // Preload while reset holds the DUTs idle; a command offered now must be ignored.
    @(negedge clk);
    cmd_valid[0] = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int k = 0; k < 2; k++) begin
        pre_en[k] = 1'b1; pre_addr[k] = 4'(a); pre_data[k] = 4'(exp_rf[k][a]);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) pre_en[k] = 1'b0;
    cmd_valid[0] = 1'b0;

    for (int k = 0; k < 2; k++) begin
      check("reset_ready", int'(cmd_ready[k]), 1);
      check("reset_rd_en", int'(rd_en1[k] | rd_en2[k]), 0);
      check("reset_rd_addr", int'(rd_addr1[k] | rd_addr2[k]), 0);
      check("reset_wr_en", int'(wr_en[k]), 0);
      check("reset_wr_data", int'(wr_data[k] | wr_addr[k]), 0);
      check("reset_flags", int'({carry[k], zero[k], done[k]}), 0);
    end
    reset = 1'b0;

    do_cmd(0, 0, 3, 1, 2);
    do_cmd(0, 1, 4, 1, 2);
    do_cmd(0, 2, 5, 2, 1);
    do_cmd(0, 5, 6, 6, 7);
    do_cmd(0, 6, 8, 6, 0);

    do_cmd(1, 0, 3, 1, 2);
    do_cmd(1, 2, 4, 4, 5);

    reset_in_exec();
    do_cmd(0, 6, 11, 3, 0);

    back_to_back();

    for (int n = 0; n < 24; n++) begin
      do_cmd(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    for (int n = 0; n < 10; n++) begin
      do_cmd(1, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
